// File: rtl/sl_bus_arbiter.sv
// sl_bus_arbiter: grants one slave-bus requester at a time and pulls its frame
// (cmd, EID, LEN, LEN payload bytes) byte-by-byte into a valid/ready byte stream
// towards the UART transmitter.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   sl_arb_request      per-interface frame-pending request
//   sl_arb_grant        one-hot grant to the interface being serviced
//   sl_data             shared slave data bus (driven by granted interface)
//   sl_data_latch       one-cycle pulse: granted interface advances a byte
//   tx_data/tx_valid    byte to the UART, held until tx_ready
//   tx_ready            UART accepts the byte when tx_valid & tx_ready
//   busy                high from grant to frame end
//   frame_done          pulse on normal frame completion
//   err_truncated       pulse when the granted request drops mid-frame
//
// Build option: define SL_ARB_FIXED_PRIORITY_EN for fixed priority (index 0
// highest); default is round-robin starting after the last serviced index.

module sl_bus_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] sl_arb_request,
  output logic [NUM_REQ-1:0] sl_arb_grant,
  input  logic [7:0]         sl_data,
  output logic               sl_data_latch,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               frame_done,
  output logic               err_truncated
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_LATCH,
    ST_SEND,
    ST_DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       len;
  logic             req_cur;
  logic             last_byte;

  assign req_cur   = sl_arb_request[idx];
  // cnt holds the number of bytes latched so far; only reaches 3+LEN once LEN is captured
  assign last_byte = (cnt == (CNT_W'(len) + CNT_W'(3)));

`ifdef SL_ARB_FIXED_PRIORITY_EN
  // Lowest set request index wins
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!pick_vld && sl_arb_request[i]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_j;

  // First set request searching upward from rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    rr_j     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rr_j = IDX_W'((32'(rr_ptr) + i) % NUM_REQ);
      if (!pick_vld && sl_arb_request[rr_j]) begin
        pick_vld = 1'b1;
        pick_idx = rr_j;
      end
    end
  end
`endif

  // Frame sequencer with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      idx           <= '0;
      cnt           <= '0;
      len           <= '0;
      sl_arb_grant  <= '0;
      sl_data_latch <= 1'b0;
      tx_data       <= '0;
      tx_valid      <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      err_truncated <= 1'b0;
`ifndef SL_ARB_FIXED_PRIORITY_EN
      rr_ptr        <= '0;
`endif
    end else begin
      sl_data_latch <= 1'b0;
      frame_done    <= 1'b0;
      err_truncated <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            idx          <= pick_idx;
            sl_arb_grant <= NUM_REQ'(1'b1) << pick_idx;
            busy         <= 1'b1;
            state        <= ST_GRANT;
          end
        end
        // settle cycle for the granted interface to drive sl_data
        ST_GRANT: state <= ST_LATCH;
        ST_LATCH: begin
          if (!req_cur) begin
            err_truncated <= 1'b1;
            sl_arb_grant  <= '0;
            busy          <= 1'b0;
            state         <= ST_DONE;
          end else begin
            tx_data       <= sl_data;
            tx_valid      <= 1'b1;
            sl_data_latch <= 1'b1;
            if (cnt == CNT_W'(2)) len <= sl_data;
            cnt           <= cnt + CNT_W'(1);
            state         <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            // completion wins: an interface may drop its request once its last byte is latched
            if (last_byte) begin
              frame_done   <= 1'b1;
              sl_arb_grant <= '0;
              busy         <= 1'b0;
              state        <= ST_DONE;
            end else if (!req_cur) begin
              err_truncated <= 1'b1;
              sl_arb_grant  <= '0;
              busy          <= 1'b0;
              state         <= ST_DONE;
            end else begin
              state <= ST_LATCH;
            end
          end
        end
        ST_DONE: begin
`ifndef SL_ARB_FIXED_PRIORITY_EN
          rr_ptr <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + IDX_W'(1);
`endif
          cnt    <= '0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sl_bus_arbiter.sv
// Bench for sl_bus_arbiter: behavioural requester streams, a frame-level
// arbitration model feeding an expected-transaction scoreboard, and a monitor
// that checks every handshake, latch pulse and frame-end pulse.
module tb_sl_bus_arbiter;

  localparam int NUM_REQ = 4;
  localparam int MEM_D   = 1024;
  localparam int MAX_FR  = 8;

  logic               clk;
  logic               rst;
  logic [NUM_REQ-1:0] sl_arb_request;
  logic [NUM_REQ-1:0] sl_arb_grant;
  logic [7:0]         sl_data;
  logic               sl_data_latch;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic               busy;
  logic               frame_done;
  logic               err_truncated;

  sl_bus_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk           (clk),
    .rst           (rst),
    .sl_arb_request(sl_arb_request),
    .sl_arb_grant  (sl_arb_grant),
    .sl_data       (sl_data),
    .sl_data_latch (sl_data_latch),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .busy          (busy),
    .frame_done    (frame_done),
    .err_truncated (err_truncated)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // requester byte streams: each interface holds back-to-back frames in mem
  logic [7:0] mem [NUM_REQ][MEM_D];
  int tot [NUM_REQ];
  int lim [NUM_REQ];      // request drops once this many bytes are latched
  int ptr [NUM_REQ];
  int fr_cnt [NUM_REQ];
  int fr_start [NUM_REQ][MAX_FR];
  int fr_len [NUM_REQ][MAX_FR];
  bit active;
  bit clr_ptr;

  typedef struct packed {
    int idx;
    int nbytes;
    bit trunc;
  } txn_t;

  txn_t       txq[$];
  logic [7:0] byteq[$];
  int         model_rr;
  int         ready_mode;
  int         stall_left;
  int         stall_cycles;

  // monitor state
  bit         in_txn;
  bit         hold_pend;
  txn_t       cur;
  int         mon_k;
  int         mon_latch;
  logic [7:0] held;

  always_comb begin
    sl_data = 8'h00;
    for (int i = 0; i < NUM_REQ; i++)
      if (sl_arb_grant[i] && ptr[i] < MEM_D) sl_data = mem[i][ptr[i]];
  end

  // requester interfaces: advance on the latch pulse, drop request at their limit
  always @(negedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rst || clr_ptr) ptr[i] = 0;
      else if (sl_data_latch && sl_arb_grant[i]) ptr[i] = ptr[i] + 1;
      sl_arb_request[i] = active && (ptr[i] < lim[i]);
    end
  end

  // UART ready: 0 always ready, 1 random, 2 stall on the LEN byte
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: tx_ready = 1'b1;
        1: tx_ready = ($urandom_range(3) != 0);
        default: begin
          if (tx_valid && mon_k == 2 && stall_left > 0) begin
            tx_ready = 1'b0;
            stall_left--;
          end else begin
            tx_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      in_txn    = 1'b0;
      hold_pend = 1'b0;
      mon_k     = 0;
    end else begin
      chk("grant_onehot0", 32'($onehot0(sl_arb_grant)), 32'd1);
      if (!in_txn && sl_arb_grant != '0) begin
        if (txq.size() == 0) begin
          chk("unexpected_grant", 32'(sl_arb_grant), 32'd0);
          cur = '{idx: 0, nbytes: 0, trunc: 1'b0};
        end else begin
          cur = txq.pop_front();
          chk("grant", 32'(sl_arb_grant), 32'(1) << cur.idx);
          chk("busy_with_grant", 32'(busy), 32'd1);
        end
        in_txn    = 1'b1;
        mon_k     = 0;
        mon_latch = 0;
      end
      if (sl_data_latch) begin
        mon_latch++;
        chk("latch_with_valid", 32'(tx_valid), 32'd1);
      end
      if (hold_pend) begin
        chk("hold_valid", 32'(tx_valid), 32'd1);
        chk("hold_data", 32'(tx_data), 32'(held));
        hold_pend = 1'b0;
      end
      if (tx_valid && tx_ready) begin
        if (byteq.size() == 0) chk("byteq_empty", 32'(byteq.size()), 32'd1);
        else chk("tx_data", 32'(tx_data), 32'(byteq.pop_front()));
        mon_k++;
      end else if (tx_valid) begin
        hold_pend = 1'b1;
        held      = tx_data;
        stall_cycles++;
      end
      if (frame_done || err_truncated) begin
        chk("pulse_in_frame", 32'(in_txn), 32'd1);
        chk("outcome", 32'({frame_done, err_truncated}), cur.trunc ? 32'd1 : 32'd2);
        chk("byte_count", 32'(mon_k), 32'(cur.nbytes));
        chk("latch_count", 32'(mon_latch), 32'(cur.nbytes));
        chk("grant_low_at_end", 32'(sl_arb_grant), 32'd0);
        chk("busy_low_at_end", 32'(busy), 32'd0);
        in_txn = 1'b0;
      end
    end
  end

  task automatic new_phase();
    active  = 1'b0;
    clr_ptr = 1'b1;
    for (int r = 0; r < NUM_REQ; r++) begin
      tot[r]    = 0;
      lim[r]    = 0;
      fr_cnt[r] = 0;
    end
    @(negedge clk);
    @(posedge clk);
    #2;
    clr_ptr = 1'b0;
  endtask

  task automatic add_frame(input int r, input logic [7:0] cmd, input logic [7:0] eid, input int len);
    int b;
    b = tot[r];
    fr_start[r][fr_cnt[r]] = b;
    fr_len[r][fr_cnt[r]]   = len + 3;
    fr_cnt[r]++;
    mem[r][b]     = cmd;
    mem[r][b + 1] = eid;
    mem[r][b + 2] = 8'(len);
    for (int k = 0; k < len; k++) mem[r][b + 3 + k] = 8'($urandom);
    tot[r] = b + len + 3;
    lim[r] = tot[r];
  endtask

  // Frame-level arbitration model: one frame per grant, pointer moves past the winner
  task automatic build_expect();
    int   fi [NUM_REQ];
    int   left;
    int   pick;
    int   start;
    int   n;
    bit   tr;
    left = 0;
    for (int r = 0; r < NUM_REQ; r++) begin
      fi[r] = 0;
      left += fr_cnt[r];
    end
    while (left > 0) begin
      pick = -1;
`ifdef SL_ARB_FIXED_PRIORITY_EN
      for (int k = 0; k < NUM_REQ; k++)
        if (pick < 0 && fi[k] < fr_cnt[k]) pick = k;
`else
      for (int k = 0; k < NUM_REQ; k++) begin
        int j;
        j = (model_rr + k) % NUM_REQ;
        if (pick < 0 && fi[j] < fr_cnt[j]) pick = j;
      end
`endif
      start = fr_start[pick][fi[pick]];
      n     = fr_len[pick][fi[pick]];
      tr    = 1'b0;
      if (lim[pick] < start + n) begin
        n  = lim[pick] - start;
        tr = 1'b1;
      end
      txq.push_back('{idx: pick, nbytes: n, trunc: tr});
      for (int k = 0; k < n; k++) byteq.push_back(mem[pick][start + k]);
      fi[pick]++;
      left--;
      model_rr = (pick + 1) % NUM_REQ;
      if (tr) begin
        left -= fr_cnt[pick] - fi[pick];
        fi[pick] = fr_cnt[pick];
      end
    end
  endtask

  task automatic go();
    @(posedge clk);
    #2;
    active = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    while ((txq.size() != 0 || in_txn || busy) && cyc < 6000) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_timeout"}, 32'(cyc < 6000), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk({name, "_bytes_left"}, 32'(byteq.size()), 32'd0);
    chk({name, "_idle_no_grant"}, 32'(sl_arb_grant), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int mask;
    int nf;
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b0;
    active       = 1'b0;
    clr_ptr      = 1'b0;
    ready_mode   = 0;
    stall_left   = 0;
    stall_cycles = 0;
    model_rr     = 0;
    for (int r = 0; r < NUM_REQ; r++) begin
      tot[r]    = 0;
      lim[r]    = 0;
      fr_cnt[r] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(sl_arb_grant), 32'd0);
    chk("rst_latch", 32'(sl_data_latch), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_err_trunc", 32'(err_truncated), 32'd0);
    #1 rst = 1'b1;

    // requesters 0,1,3 each hold two LEN=0 frames
    new_phase();
    for (int f = 0; f < 2; f++) begin
      add_frame(0, 8'h20, 8'h00, 0);
      add_frame(1, 8'h21, 8'h01, 0);
      add_frame(3, 8'h23, 8'h03, 0);
    end
    build_expect();
    go();
    wait_done("rr");

    // single frame 56 05 02 AA BB on requester 1; tx_valid 3 cycles after request
    new_phase();
    add_frame(1, 8'h56, 8'h05, 2);
    mem[1][3] = 8'hAA;
    mem[1][4] = 8'hBB;
    build_expect();
    go();
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!tx_valid && cyc < 20);
    chk("first_valid_latency", 32'(cyc), 32'd4);
    wait_done("single");

    // 10-cycle backpressure on the LEN byte
    new_phase();
    ready_mode   = 2;
    stall_left   = 10;
    stall_cycles = 0;
    add_frame(0, 8'h11, 8'h00, 3);
    build_expect();
    go();
    wait_done("stall");
    chk("stall_cycles", 32'(stall_cycles), 32'd10);
    chk("stall_used", 32'(stall_left), 32'd0);

    // LEN=255: 258 bytes without counter wrap
    new_phase();
    ready_mode = 0;
    add_frame(1, 8'h40, 8'h07, 255);
    build_expect();
    go();
    wait_done("len255");

    // truncation: requester 2 drops after byte 3 of a LEN=4 frame, then requester 3
    new_phase();
    add_frame(2, 8'h50, 8'h02, 4);
    lim[2] = 3;
    add_frame(3, 8'h51, 8'h03, 1);
    build_expect();
    go();
    wait_done("trunc");

    // async reset during SEND of the first byte, then restart from byte 0
    new_phase();
    add_frame(2, 8'h31, 8'h02, 5);
    add_frame(3, 8'h32, 8'h03, 2);
    build_expect();
    go();
    cyc = 0;
    while (!tx_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_reach_send", 32'(tx_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_grant", 32'(sl_arb_grant), 32'd0);
    chk("arst_tx_valid", 32'(tx_valid), 32'd0);
    chk("arst_tx_data", 32'(tx_data), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_latch", 32'(sl_data_latch), 32'd0);
    chk("arst_pulses", 32'({frame_done, err_truncated}), 32'd0);
    txq.delete();
    byteq.delete();
    model_rr = 0;
    @(negedge clk);
    @(negedge clk);
    build_expect();
    #1 rst = 1'b1;
    wait_done("after_reset");

    // randomized phases
    for (int ph = 0; ph < 25; ph++) begin
      new_phase();
      ready_mode = $urandom_range(1);
      mask = $urandom_range(15, 1);
      for (int r = 0; r < NUM_REQ; r++) begin
        if (mask[r]) begin
          nf = $urandom_range(3, 1);
          for (int f = 0; f < nf; f++)
            add_frame(r, 8'($urandom), 8'($urandom), $urandom_range(12));
          if (nf == 1 && $urandom_range(3) == 0) lim[r] = $urandom_range(tot[r] - 1, 1);
        end
      end
      build_expect();
      go();
      wait_done("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sl_bus_arbiter.md
Name: sl_bus_arbiter

Overview:
- Downstream consumer of the shared slave output bus: arbitrates among NUM_REQ bus interfaces (basics, I2C, GOC, etc.) that raise sl_arb_request.
- Grants one requester at a time and pulls its frame byte-by-byte with sl_data_latch.
- Forwards each byte to the UART transmit path over a valid/ready byte handshake.
- Frame format on the slave bus, as produced by message_fifo with length population: byte0 command, byte1 EID, byte2 LEN, then LEN payload bytes.

Parameters:
NUM_REQ, 4, number of slave-bus requesters (2..8)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
sl_arb_request  input  NUM_REQ  per-interface frame-pending request
sl_arb_grant  output  NUM_REQ  one-hot grant; at most one bit high
sl_data  input  8  shared slave data bus, driven by the granted interface
sl_data_latch  output  1  single-cycle pulse; granted interface advances to next byte
tx_data  output  8  byte to UART transmitter
tx_valid  output  1  tx_data valid
tx_ready  input  1  UART accepts byte when tx_valid & tx_ready
busy  output  1  high from grant through frame end
frame_done  output  1  one-cycle pulse at normal frame completion
err_truncated  output  1  one-cycle pulse when granted request drops mid-frame

Behaviour:
- Reset (rst low, asynchronous):
  - State IDLE; all outputs 0; rr_ptr=0; byte counter=0; LEN register=0.
  - Reset mid-frame abandons the frame with no pulses.
- State IDLE:
  - If any sl_arb_request bit is set, select the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Latch the selected index; go to GRANT.
- State GRANT:
  - sl_arb_grant[idx]=1 and busy=1; these stay high through LATCH and SEND.
  - One settle cycle for sl_data; go to LATCH.
- State LATCH:
  - tx_data<=sl_data; sl_data_latch=1 this cycle only.
  - If counter==2, LEN<=sl_data.
  - Counter increments (9-bit; LEN=255 gives 258 bytes).
  - Go to SEND.
- State SEND:
  - tx_valid=1; tx_data held stable until handshake.
  - On tx_valid&tx_ready: if counter==3+LEN (counter≥3), go to DONE with frame_done=1; else go to LATCH.
  - No handshake: stay.
- State DONE:
  - Grant and busy drop; rr_ptr<=(idx+1) mod NUM_REQ; counter<=0; go to IDLE.
  - Earliest next grant is 2 cycles after the last handshake.
- Throughput and latency:
  - Minimum 2 cycles per byte (LATCH+SEND with tx_ready tied high).
  - First tx_valid appears 3 cycles after request is seen in IDLE.
- Truncation:
  - In LATCH or SEND, if sl_arb_request[idx] is low, the byte in SEND still completes its handshake.
  - Then err_truncated=1 (not frame_done) and go to DONE.
  - If the request is low in LATCH, no latch pulse is issued, and err_truncated pulses immediately.
- LEN=0: frame is exactly 3 bytes.
- Requests from other interfaces during a frame are ignored until IDLE.
- Request arriving the same cycle DONE is entered: serviced on the next IDLE pass by rr_ptr order.
- sl_arb_grant must never have more than one bit set; assertion in bench.

Optional Feature:
SL_ARB_FIXED_PRIORITY_EN
- Defined: IDLE always selects the lowest-index set request (index 0 highest); rr_ptr is not used.
- Undefined (default): round-robin as above.

Test Plan:
1. Single frame: req[1] with bytes 0x56,0x05,0x02,0xAA,0xBB, tx_ready=1 → grant=4'b0010; tx sequence 56,05,02,AA,BB; 5 sl_data_latch pulses; frame_done at last handshake; grant low next cycle.
2. Round-robin: req=4'b1011 held, each frame LEN=0 → grant order 0,1,3,0; with SL_ARB_FIXED_PRIORITY_EN the order is 0,0,0.
3. Backpressure: tx_ready low 10 cycles on byte 2 → tx_valid and tx_data=LEN held stable 10 cycles; no extra sl_data_latch; frame completes intact.
4. Boundary LEN=0 and LEN=255: → exactly 3 and 258 bytes transmitted respectively; counter does not wrap.
5. Truncation: req[2] drops after byte 3 of LEN=4 frame → byte 3 completes; err_truncated pulses once; no frame_done; next requester granted.
6. Async reset asserted during SEND of byte 1 → all outputs 0 immediately; after release, a pending request restarts from byte 0 with grant to lowest index ≥0.
